logic_unit_pipe: RTL and testbench

// Parametrised, registered logic unit. It succeeds the fixed 1-/4-bit AND/OR/NAND gate cells.
// - One WIDTH-bit datapath with runtime-selectable gate operation.
// - Valid/ready handshake on input and output, with one pipeline register.
// - Accumulate mode folds each result into an internal register.
// - Registered reduction flags (zero, all-ones, parity) on the output.

---
 rtl/logic_unit_pipe.sv | 85 ++++++++
 tb/tb_logic_unit_pipe.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/logic_unit_pipe.sv
// Purpose  : WIDTH-bit registered gate unit (AND/OR/NAND/NOR/XOR/XNOR/NOT/PASS) with accumulator and reduction flags.
// Latency  : 1 cycle from input acceptance to out_y/out_valid.
// Backpress: in_ready = !out_valid || out_ready; a stalled output beat holds out_y and flags stable.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid/in_ready          input handshake; in_op, in_acc, in_a, in_b form the beat
//   acc_clr                    synchronous accumulator clear (wins over accumulate update)
//   out_valid/out_ready        output handshake
//   out_y, out_zero, out_ones, out_parity   registered result and its reduction flags
module logic_unit_pipe #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic             in_acc,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic             out_zero,
    output logic             out_ones,
    output logic             out_parity
);

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] result;
    logic             accept;

    // Output register is free when empty or being drained this cycle.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign op_a     = in_acc ? acc : in_a;

    always_comb begin
        result = op_a;
        case (in_op)
            3'd0:    result = op_a & in_b;
            3'd1:    result = op_a | in_b;
            3'd2:    result = ~(op_a & in_b);
            3'd3:    result = ~(op_a | in_b);
            3'd4:    result = op_a ^ in_b;
            3'd5:    result = ~(op_a ^ in_b);
            3'd6:    result = ~op_a;
            default: result = op_a;
        endcase
    end

    // Output stage: load on accept, otherwise drop valid once consumed; data held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_y      <= '0;
            out_zero   <= 1'b1;
            out_ones   <= 1'b0;
            out_parity <= 1'b0;
        end else if (accept) begin
            out_valid  <= 1'b1;
            out_y      <= result;
            out_zero   <= ~|result;
            out_ones   <= &result;
            out_parity <= ^result;
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

    // Clear has priority; the same-cycle beat still used the old acc via op_a.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (acc_clr) begin
            acc <= '0;
        end else if (accept && in_acc) begin
            acc <= result;
        end
    end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Purpose  : directed bench for logic_unit_pipe at WIDTH=4.
// Latency  : expects results one edge after acceptance.
// Backpress: exercises output stalls, accumulator priority and asynchronous reset mid-stall.
module tb_logic_unit_pipe;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   in_op;
    logic         in_acc;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         acc_clr;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_y;
    logic         out_zero;
    logic         out_ones;
    logic         out_parity;

    int checks = 0;
    int errors = 0;

    localparam logic [2:0] OP_AND = 3'd0, OP_OR = 3'd1, OP_NAND = 3'd2, OP_NOR = 3'd3,
                           OP_XOR = 3'd4, OP_XNOR = 3'd5, OP_NOT = 3'd6, OP_PASS = 3'd7;

    always #5 clk = ~clk;

    logic_unit_pipe #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_acc     (in_acc),
        .in_a       (in_a),
        .in_b       (in_b),
        .acc_clr    (acc_clr),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_y      (out_y),
        .out_zero   (out_zero),
        .out_ones   (out_ones),
        .out_parity (out_parity)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Checks valid, data and all three flags against hand-written values.
    task automatic chk_out(input string tag, input logic v, input logic [W-1:0] y,
                           input logic z, input logic o, input logic p);
        chk({tag, ".valid"},  32'(out_valid),  32'(v));
        chk({tag, ".y"},      32'(out_y),      32'(y));
        chk({tag, ".zero"},   32'(out_zero),   32'(z));
        chk({tag, ".ones"},   32'(out_ones),   32'(o));
        chk({tag, ".parity"}, 32'(out_parity), 32'(p));
    endtask

    // Present one beat for exactly one edge, then sample 1 time unit later.
    task automatic send(input logic [2:0] op, input logic acc, input logic [W-1:0] a,
                        input logic [W-1:0] b);
        in_op    = op;
        in_acc   = acc;
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_op     = OP_AND;
        in_acc    = 1'b0;
        in_a      = '0;
        in_b      = '0;
        acc_clr   = 1'b0;
        out_ready = 1'b1;

        #12;
        chk_out("reset", 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0);
        chk("reset.in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic gate operations, out_ready held high.
        send(OP_AND, 1'b0, 4'b1010, 4'b0101);
        chk_out("and", 1'b1, 4'b0000, 1'b1, 1'b0, 1'b0);
        send(OP_XOR, 1'b0, 4'b1010, 4'b0101);
        chk_out("xor", 1'b1, 4'b1111, 1'b0, 1'b1, 1'b0);
        send(OP_NAND, 1'b0, 4'b1111, 4'b1111);
        chk_out("nand", 1'b1, 4'b0000, 1'b1, 1'b0, 1'b0);
        send(OP_NOR, 1'b0, 4'b0000, 4'b0001);
        chk_out("nor", 1'b1, 4'b1110, 1'b0, 1'b0, 1'b1);
        send(OP_XNOR, 1'b0, 4'b1100, 4'b1010);
        chk_out("xnor", 1'b1, 4'b1001, 1'b0, 1'b0, 1'b0);
        send(OP_NOT, 1'b0, 4'b0011, 4'b1111);
        chk_out("not", 1'b1, 4'b1100, 1'b0, 1'b0, 1'b0);
        send(OP_PASS, 1'b0, 4'b0110, 4'b1001);
        chk_out("pass", 1'b1, 4'b0110, 1'b0, 1'b0, 1'b0);
        send(OP_OR, 1'b0, 4'b1000, 4'b0001);
        chk_out("or", 1'b1, 4'b1001, 1'b0, 1'b0, 1'b0);
        idle();
        chk_out("drain", 1'b0, 4'b1001, 1'b0, 1'b0, 1'b0);

        // Output stall: beat 1 lands, beat 2 waits.
        out_ready = 1'b0;
        send(OP_OR, 1'b0, 4'b0011, 4'b0100);
        chk_out("stall.b1", 1'b1, 4'b0111, 1'b0, 1'b0, 1'b1);
        in_op    = OP_AND;
        in_a     = 4'b1111;
        in_b     = 4'b1100;
        in_valid = 1'b1;
        #1;
        chk("stall.in_ready", 32'(in_ready), 32'd0);
        for (int i = 0; i < 5; i++) begin
            idle();
            chk_out("stall.hold", 1'b1, 4'b0111, 1'b0, 1'b0, 1'b1);
            chk("stall.hold.in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        #1;
        chk("stall.release.in_ready", 32'(in_ready), 32'd1);
        idle();
        in_valid = 1'b0;
        chk_out("stall.b2", 1'b1, 4'b1100, 1'b0, 1'b0, 1'b0);
        idle();
        chk("stall.drain.valid", 32'(out_valid), 32'd0);

        // Accumulator: OR-in single bits, then clear colliding with an accumulate beat.
        acc_clr = 1'b1;
        idle();
        acc_clr = 1'b0;
        send(OP_OR, 1'b1, 4'b0000, 4'b0001);
        chk_out("acc.1", 1'b1, 4'b0001, 1'b0, 1'b0, 1'b1);
        send(OP_OR, 1'b1, 4'b0000, 4'b0010);
        chk_out("acc.2", 1'b1, 4'b0011, 1'b0, 1'b0, 1'b0);
        send(OP_OR, 1'b1, 4'b0000, 4'b0100);
        chk_out("acc.3", 1'b1, 4'b0111, 1'b0, 1'b0, 1'b1);
        acc_clr = 1'b1;
        send(OP_OR, 1'b1, 4'b0000, 4'b1000);
        acc_clr = 1'b0;
        chk_out("acc.clr_beat", 1'b1, 4'b1111, 1'b0, 1'b1, 1'b0);
        send(OP_OR, 1'b1, 4'b0000, 4'b1000);
        chk_out("acc.after_clr", 1'b1, 4'b1000, 1'b0, 1'b0, 1'b1);
        send(OP_AND, 1'b0, 4'b0000, 4'b0000);
        chk_out("acc.bypass", 1'b1, 4'b0000, 1'b1, 1'b0, 1'b0);
        send(OP_PASS, 1'b1, 4'b0000, 4'b0000);
        chk_out("acc.kept", 1'b1, 4'b1000, 1'b0, 1'b0, 1'b1);

        // Streaming: four back-to-back beats, valid never drops.
        for (int i = 1; i <= 4; i++) begin
            chk("stream.in_ready", 32'(in_ready), 32'd1);
            send(OP_PASS, 1'b0, 4'(i), 4'b0000);
            chk("stream.valid", 32'(out_valid), 32'd1);
            chk("stream.y", 32'(out_y), 32'(i));
        end
        idle();
        chk("stream.drain.valid", 32'(out_valid), 32'd0);

        // Asynchronous reset during a stall (acc holds 1000 at this point).
        out_ready = 1'b0;
        send(OP_PASS, 1'b0, 4'b0101, 4'b0000);
        chk_out("rst.pre", 1'b1, 4'b0101, 1'b0, 1'b0, 1'b0);
        in_op    = OP_XOR;
        in_a     = 4'b1111;
        in_valid = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        chk_out("rst.async", 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0);
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        chk_out("rst.held", 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        send(OP_PASS, 1'b1, 4'b1111, 4'b0000);
        chk_out("rst.acc_zero", 1'b1, 4'b0000, 1'b1, 1'b0, 1'b0);
        send(OP_XOR, 1'b0, 4'b1100, 4'b0111);
        chk_out("rst.after", 1'b1, 4'b1011, 1'b0, 1'b0, 1'b1);
        idle();
        chk("rst.after.drain", 32'(out_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
